// File: rtl/mnd_eval_sched_if.sv
// ---------------------------------------------------------------------------
// mnd_eval_sched_if
// Bundles the request/grant bus and the dynamic-macro signals of the
// mnd_eval_sched block.
//   REQ      : level request flags, one per requester
//   REQ_DATA : packed operands, requester i at [i*DW +: DW]
//   GNT      : one-hot grant pulse
//   DYN_CK   : dynamic-gate clock (0 = precharge, 1 = evaluate)
//   DYN_IN   : operand driven to the dynamic macro
//   DYN_OUT  : dynamic macro output
//   RES_VLD  : one-cycle result-valid pulse
//   RES      : captured result
//   RES_ID   : index of the requester that owns RES
//   BUSY     : high whenever the scheduler is not idle
// Modports: master = requesters + macro side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface mnd_eval_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]    REQ;
    logic [NREQ*DW-1:0] REQ_DATA;
    logic [NREQ-1:0]    GNT;
    logic               DYN_CK;
    logic [DW-1:0]      DYN_IN;
    logic [DW-1:0]      DYN_OUT;
    logic               RES_VLD;
    logic [DW-1:0]      RES;
    logic [ID_W-1:0]    RES_ID;
    logic               BUSY;

    modport master (
        output REQ, REQ_DATA, DYN_OUT,
        input  GNT, DYN_CK, DYN_IN, RES_VLD, RES, RES_ID, BUSY
    );

    modport slave (
        input  REQ, REQ_DATA, DYN_OUT,
        output GNT, DYN_CK, DYN_IN, RES_VLD, RES, RES_ID, BUSY
    );
endinterface

// File: rtl/mnd_eval_sched.sv
// ---------------------------------------------------------------------------
// mnd_eval_sched
// Round-robin scheduler that shares one precharge/evaluate dynamic macro
// between NREQ requesters. A granted operand is latched and held on DYN_IN
// through PCH_CYC precharge cycles (DYN_CK=0) and EVAL_CYC evaluate cycles
// (DYN_CK=1); DYN_OUT is then captured into RES and flagged for one cycle.
//
// Ports:
//   CK  : clock, all state changes on the rising edge
//   RST : synchronous active-high reset
//   bus : mnd_eval_sched_if.slave (REQ, REQ_DATA, GNT, DYN_CK, DYN_IN,
//         DYN_OUT, RES_VLD, RES, RES_ID, BUSY)
//
// Build option:
//   MND_EVAL_SCHED_PRIO0_EN - when defined, requester 0 has fixed priority
//   and its grants do not advance the round-robin pointer.
// ---------------------------------------------------------------------------
module mnd_eval_sched #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int PCH_CYC  = 2,
    parameter int EVAL_CYC = 1
) (
    input logic               CK,
    input logic               RST,
    mnd_eval_sched_if.slave   bus
);
    localparam int ID_W    = $clog2(NREQ);
    localparam int CNT_MAX = (PCH_CYC > EVAL_CYC) ? PCH_CYC : EVAL_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PCH  = 2'd1,
        S_EVAL = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   r_owner;
    logic [NREQ-1:0]   r_gnt;
    logic              r_dyn_ck;
    logic [DW-1:0]     r_dyn_in;
    logic              r_res_vld;
    logic [DW-1:0]     r_res;
    logic [ID_W-1:0]   r_res_id;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [DW-1:0]     w_opnd;

    // Round-robin search starting one past the last grant and wrapping.
    always_comb begin
        logic [ID_W-1:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ID_W'((int'(r_last) + k) % NREQ);
            if (!w_found && bus.REQ[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
`ifdef MND_EVAL_SCHED_PRIO0_EN
        if (bus.REQ[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    assign w_opnd = bus.REQ_DATA[int'(w_win)*DW +: DW];

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= ID_W'(NREQ - 1);
            r_owner   <= '0;
            r_gnt     <= '0;
            r_dyn_ck  <= 1'b0;
            r_dyn_in  <= '0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
            r_res_id  <= '0;
        end else begin
            // Grant and result-valid are single-cycle pulses.
            r_gnt     <= '0;
            r_res_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dyn_ck <= 1'b0;
                    if (w_found) begin
                        r_state  <= S_PCH;
                        r_gnt    <= NREQ'(1) << w_win;
                        r_owner  <= w_win;
                        r_dyn_in <= w_opnd;
                        r_cnt    <= CNT_W'(PCH_CYC - 1);
`ifdef MND_EVAL_SCHED_PRIO0_EN
                        // Priority grants to requester 0 must not disturb
                        // the rotation among the others.
                        if (w_win != '0) begin
                            r_last <= w_win;
                        end
`else
                        r_last   <= w_win;
`endif
                    end else begin
                        r_dyn_in <= '0;
                    end
                end
                S_PCH: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_EVAL;
                        r_dyn_ck <= 1'b1;
                        r_cnt    <= CNT_W'(EVAL_CYC - 1);
                    end else begin
                        r_cnt    <= r_cnt - CNT_W'(1);
                    end
                end
                S_EVAL: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_CAP;
                        r_dyn_ck  <= 1'b0;
                        r_dyn_in  <= '0;
                        r_res     <= bus.DYN_OUT;
                        r_res_id  <= r_owner;
                        r_res_vld <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt - CNT_W'(1);
                    end
                end
                S_CAP: begin
                    r_state  <= S_IDLE;
                    r_dyn_ck <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_dyn_ck <= 1'b0;
                end
            endcase
        end
    end

    assign bus.GNT     = r_gnt;
    assign bus.DYN_CK  = r_dyn_ck;
    assign bus.DYN_IN  = r_dyn_in;
    assign bus.RES_VLD = r_res_vld;
    assign bus.RES     = r_res;
    assign bus.RES_ID  = r_res_id;
    assign bus.BUSY    = (r_state != S_IDLE);

endmodule

// File: doc/mnd_eval_sched.md
MND_EVAL_SCHED -- requirements
Module: mnd_eval_sched

Interface
- REQ-001: Parameter NREQ, default 4, is the number of requesters (2..8).
- REQ-002: Parameter DW, default 8, is the operand/result width.
- REQ-003: Parameter PCH_CYC, default 2, is the number of precharge cycles per operation (>=1).
- REQ-004: Parameter EVAL_CYC, default 1, is the number of evaluate cycles per operation (>=1).
- REQ-005: Port CK, input, width 1, is the single clock; all state changes on rising edge.
- REQ-006: Port RST, input, width 1, is the synchronous, active-high reset.
- REQ-007: Port REQ, input, width NREQ, carries level request flags, one per requester.
- REQ-008: Port REQ_DATA, input, width NREQ*DW, carries operands; requester i uses slice [i*DW +: DW].
- REQ-009: Port GNT, output, width NREQ, is a one-hot grant pulse.
- REQ-010: Port DYN_CK, output, width 1, is the dynamic-gate clock: 0 = precharge, 1 = evaluate.
- REQ-011: Port DYN_IN, output, width DW, carries the operand driven to the dynamic macro inputs.
- REQ-012: Port DYN_OUT, input, width DW, returns the dynamic macro output.
- REQ-013: Port RES_VLD, output, width 1, is a one-cycle result-valid pulse.
- REQ-014: Port RES, output, width DW, carries the captured result.
- REQ-015: Port RES_ID, output, width clog2(NREQ), carries the index of the requester that owns RES.
- REQ-016: Port BUSY, output, width 1, is high in every state except IDLE.

Function
- REQ-017: The FSM SHALL have the states IDLE, PCH, EVAL and CAP.
- REQ-018: In IDLE with REQ!=0 at an edge, the block SHALL arbitrate, latch the winner's REQ_DATA and index, assert GNT for exactly the first PCH cycle, and enter PCH.
- REQ-019: In IDLE with REQ==0, the block SHALL stay in IDLE with DYN_CK=0, GNT=0 and DYN_IN=0.
- REQ-020: PCH SHALL last PCH_CYC cycles with DYN_CK=0; EVAL SHALL then last EVAL_CYC cycles with DYN_CK=1.
- REQ-021: DYN_IN SHALL hold the latched operand, unchanged, for all of PCH and EVAL, regardless of REQ_DATA changes.
- REQ-022: At the edge ending the last EVAL cycle, the block SHALL register DYN_OUT into RES and enter CAP.
- REQ-023: CAP SHALL last one cycle with DYN_CK=0, RES_VLD=1 and RES_ID=owner, then return to IDLE.
- REQ-024: RES and RES_ID SHALL hold their values until the next CAP.
- REQ-025: Latency, counted from the IDLE cycle that samples REQ as cycle 0, SHALL be: GNT at cycle 1 and RES_VLD at cycle PCH_CYC+EVAL_CYC+1.
- REQ-026: Peak throughput SHALL be one operation per PCH_CYC+EVAL_CYC+2 cycles.
- REQ-027: Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps from NREQ-1 to 0.
- REQ-028: REQ held after GNT SHALL be treated as a new request at the next IDLE.
- REQ-029: DYN_CK SHALL never be 1 outside EVAL, and at most one GNT bit SHALL be set.

Reset
- REQ-030: RST=1 at an edge SHALL force IDLE, DYN_CK=0, GNT=0, DYN_IN=0, RES_VLD=0, RES=0, RES_ID=0, BUSY=0 and last_grant=NREQ-1, from any state.
- REQ-031: RST asserted mid-operation SHALL discard the in-flight operation with no RES_VLD.

Configuration
- REQ-032: With MND_EVAL_SCHED_PRIO0_EN defined, requester 0 SHALL win whenever REQ[0]=1, and grants to requester 0 SHALL leave last_grant unchanged; the others SHALL rotate round-robin.
- REQ-033: Without MND_EVAL_SCHED_PRIO0_EN, all requesters SHALL be pure round-robin per REQ-027.

Verification (NREQ=4, DW=8, PCH_CYC=2, EVAL_CYC=1)
- REQ-034: After reset, REQ=0001, REQ_DATA[7:0]=0xA5 and DYN_OUT=0x3C SHALL give: GNT=0001 at cycle 1; DYN_CK=0,0,1 in cycles 1-3; DYN_IN=0xA5 in cycles 1-3; RES_VLD=1, RES=0x3C, RES_ID=0 at cycle 4.
- REQ-035: After reset, REQ=1111 held SHALL produce grants to 0,1,2,3,0, one every 5 cycles.
- REQ-036: With last_grant=3 and REQ=1001 held, the grant order SHALL be 0, 3, 0.
- REQ-037: RST pulsed during EVAL SHALL give DYN_CK=0 and BUSY=0 next cycle and no RES_VLD; a following REQ=0010 SHALL be granted normally.
- REQ-038: Changing REQ_DATA to 0xFF during PCH/EVAL SHALL leave DYN_IN at the latched 0xA5.
- REQ-039: With the macro defined and REQ=1111 held, every grant SHALL go to 0; with REQ=1110, the grant order SHALL be 1, 2, 3.
